// File: rtl/warp_pkg.sv
// warp_pkg
// Shared types and defaults for the warp fetch arbiter slice.
//   arb_state_e         : arbiter FSM states (ARB_IDLE, ARB_ISSUE, ARB_WAIT)
//   NUM_WARPS_DEFAULT   : default number of requesting warp controllers
//   ARB_TIMEOUT_DEFAULT : default response timeout in cycles
package warp_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_ISSUE = 2'b01,
        ARB_WAIT  = 2'b10
    } arb_state_e;

    localparam int NUM_WARPS_DEFAULT   = 4;
    localparam int ARB_TIMEOUT_DEFAULT = 256;

endpackage

// File: rtl/warp_rr_pick.sv
// warp_rr_pick
// Purely combinational round-robin picker: finds the first set bit of req
// at or after ptr, wrapping from the top index back to 0.
// Ports:
//   req   in  N     request mask
//   ptr   in  PW    search start index (always < N)
//   found out 1     any bit of req set
//   index out PW    winning index (0 when nothing is found)
module warp_rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          found,
    output logic [PW-1:0] index
);

    int j;

    // Walk the candidates from farthest to nearest so the last hit, which is
    // the closest one at or after ptr, is the one that sticks.
    always_comb begin
        found = |req;
        index = '0;
        j     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (req[j]) begin
                index = PW'(j);
            end
        end
    end

endmodule

// File: rtl/warp_fetch_arbiter.sv
// warp_fetch_arbiter
// Shares one instruction-memory port between NUM_WARPS warp controllers.
// Grants one warp at a time in round-robin order, keeps one transaction
// outstanding, routes the response back to the owning warp and aborts a
// transaction whose response does not arrive within TIMEOUT_CYCLES.
//
// Optional build macro: WARP_FETCH_ARB_PRIO_EN adds the warp_prio input; when
// any requesting warp also has its prio bit set, only those warps compete
// (round-robin from the shared rr pointer inside that class).
//
// Handshakes:
//   warp side : warp_req is a level held until warp_ack; warp_ack is a
//               one-cycle pulse in ARB_IDLE; warp_valid / warp_err are
//               one-cycle pulses that end the transaction for owner.
//   mem side  : a request transfers on a cycle with mem_req && mem_ready;
//               mem_req stays high and mem_addr stable until then. mem_valid
//               is only honoured in ARB_ISSUE (on the accepting cycle) and
//               ARB_WAIT.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   warp_req    : per-warp fetch request
//   warp_addr   : packed per-warp address, warp i at [i*ADDR_W +: ADDR_W]
//   warp_ack    : one-hot, request latched
//   warp_valid  : one-hot, response for the warp on warp_rdata
//   warp_err    : one-hot, transaction timed out
//   warp_rdata  : response data (zero when no response this cycle)
//   mem_req/mem_addr/mem_ready : memory request channel
//   mem_valid/mem_rdata        : memory response channel
//   owner       : current or last granted warp
//   busy        : FSM is not in ARB_IDLE
module warp_fetch_arbiter
    import warp_pkg::*;
#(
    parameter int NUM_WARPS      = NUM_WARPS_DEFAULT,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_WARPS-1:0]          warp_req,
    input  logic [NUM_WARPS*ADDR_W-1:0]   warp_addr,
`ifdef WARP_FETCH_ARB_PRIO_EN
    input  logic [NUM_WARPS-1:0]          warp_prio,
`endif
    output logic [NUM_WARPS-1:0]          warp_ack,
    output logic [NUM_WARPS-1:0]          warp_valid,
    output logic [NUM_WARPS-1:0]          warp_err,
    output logic [DATA_W-1:0]             warp_rdata,
    output logic                          mem_req,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic                          mem_ready,
    input  logic                          mem_valid,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [$clog2(NUM_WARPS)-1:0]  owner,
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_WARPS);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TMR_W-1:0]     TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_WARPS-1:0] ONE_HOT0 = {{(NUM_WARPS-1){1'b0}}, 1'b1};

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TMR_W-1:0]  timer_q, timer_d;

    logic [NUM_WARPS-1:0] ack_c;
    logic                 resp_fire;
    logic                 err_fire;
    logic                 issue_c;
    logic [IDX_W-1:0]     owner_inc;

    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic                 all_found;
    logic [IDX_W-1:0]     all_idx;

    warp_rr_pick #(.N(NUM_WARPS), .PW(IDX_W)) u_pick_all (
        .req   (warp_req),
        .ptr   (rr_ptr_q),
        .found (all_found),
        .index (all_idx)
    );

`ifdef WARP_FETCH_ARB_PRIO_EN
    logic [NUM_WARPS-1:0] prio_req;
    logic                 prio_found;
    logic [IDX_W-1:0]     prio_idx;

    assign prio_req = warp_req & warp_prio;

    warp_rr_pick #(.N(NUM_WARPS), .PW(IDX_W)) u_pick_prio (
        .req   (prio_req),
        .ptr   (rr_ptr_q),
        .found (prio_found),
        .index (prio_idx)
    );

    // The priority class wins whenever it is non-empty; both classes share
    // the one rr pointer.
    assign pick_found = all_found;
    assign pick_idx   = prio_found ? prio_idx : all_idx;
`else
    assign pick_found = all_found;
    assign pick_idx   = all_idx;
`endif

    // Modulo increment that also works for non-power-of-2 warp counts.
    assign owner_inc = (int'(owner_q) == NUM_WARPS - 1) ? '0 : owner_q + IDX_W'(1);

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        timer_d   = timer_q;
        ack_c     = '0;
        resp_fire = 1'b0;
        err_fire  = 1'b0;
        issue_c   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    ack_c   = ONE_HOT0 << pick_idx;
                    owner_d = pick_idx;
                    addr_d  = warp_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                issue_c = 1'b1;
                if (mem_ready) begin
                    if (mem_valid) begin
                        // Memory answered on the accepting cycle itself.
                        resp_fire = 1'b1;
                        rr_ptr_d  = owner_inc;
                        state_d   = ARB_IDLE;
                    end else begin
                        timer_d = '0;
                        state_d = ARB_WAIT;
                    end
                end
            end
            ARB_WAIT: begin
                timer_d = timer_q + TMR_W'(1);
                // A response on the timeout cycle still counts as a response.
                if (mem_valid) begin
                    resp_fire = 1'b1;
                    rr_ptr_d  = owner_inc;
                    timer_d   = '0;
                    state_d   = ARB_IDLE;
                end else if (timer_q == TMR_LAST) begin
                    err_fire = 1'b1;
                    rr_ptr_d = owner_inc;
                    timer_d  = '0;
                    state_d  = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            addr_q   <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            timer_q  <= timer_d;
        end
    end

    // The grant is combinational from warp_req, so it is held off while in
    // reset to keep every output quiet.
    assign warp_ack   = rst_n ? ack_c : '0;
    assign warp_valid = resp_fire ? (ONE_HOT0 << owner_q) : '0;
    assign warp_err   = err_fire ? (ONE_HOT0 << owner_q) : '0;
    assign warp_rdata = resp_fire ? mem_rdata : '0;
    assign mem_req    = issue_c;
    assign mem_addr   = addr_q;
    assign owner      = owner_q;
    assign busy       = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_warp_fetch_arbiter.sv
// tb_warp_fetch_arbiter
// Directed bench for warp_fetch_arbiter (NUM_WARPS=4, TIMEOUT_CYCLES=8).
// Stimulus pushes expected events (grant, memory issue, response, error)
// into exp_q; a monitor on the falling edge pops and compares every event
// the DUT presents. The main thread additionally checks exact cycle timing.
module tb_warp_fetch_arbiter;

    localparam int NW = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam int EW = 38;

    localparam logic [1:0] K_MEM = 2'd0;
    localparam logic [1:0] K_ACK = 2'd1;
    localparam logic [1:0] K_VAL = 2'd2;
    localparam logic [1:0] K_ERR = 2'd3;

    logic            clk;
    logic            rst_n;
    logic [NW-1:0]   warp_req;
    logic [NW*AW-1:0] warp_addr;
`ifdef WARP_FETCH_ARB_PRIO_EN
    logic [NW-1:0]   warp_prio;
`endif
    logic [NW-1:0]   warp_ack;
    logic [NW-1:0]   warp_valid;
    logic [NW-1:0]   warp_err;
    logic [DW-1:0]   warp_rdata;
    logic            mem_req;
    logic [AW-1:0]   mem_addr;
    logic            mem_ready;
    logic            mem_valid;
    logic [DW-1:0]   mem_rdata;
    logic [1:0]      owner;
    logic            busy;

    logic [EW-1:0]   exp_q[$];
    int              checks;
    int              errors;

    warp_fetch_arbiter #(
        .NUM_WARPS      (NW),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .warp_req   (warp_req),
        .warp_addr  (warp_addr),
`ifdef WARP_FETCH_ARB_PRIO_EN
        .warp_prio  (warp_prio),
`endif
        .warp_ack   (warp_ack),
        .warp_valid (warp_valid),
        .warp_err   (warp_err),
        .warp_rdata (warp_rdata),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_valid  (mem_valid),
        .mem_rdata  (mem_rdata),
        .owner      (owner),
        .busy       (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [AW-1:0] addr_of(input int w);
        case (w)
            0:       addr_of = 32'h0000_0100;
            1:       addr_of = 32'h0000_0200;
            2:       addr_of = 32'h0000_1000;
            default: addr_of = 32'h0000_3000;
        endcase
    endfunction

    function automatic logic [EW-1:0] mk_ev(input logic [1:0] k, input logic [3:0] w,
                                             input logic [31:0] d);
        mk_ev = {k, w, d};
    endfunction

    function automatic logic [3:0] enc(input logic [3:0] v);
        enc = 4'hF;
        for (int i = 0; i < 4; i++) begin
            if (v == (4'b0001 << i)) enc = 4'(i);
        end
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_ev(input string name, input logic [EW-1:0] act);
        logic [EW-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected event 0x%0h at %0t", name, act, $time);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got event 0x%0h expected 0x%0h at %0t", name, act, e, $time);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (warp_ack != '0)  chk_ev("ack_event", mk_ev(K_ACK, enc(warp_ack), 32'h0));
            if (mem_req && mem_ready) chk_ev("mem_issue", mk_ev(K_MEM, 4'h0, mem_addr));
            if (warp_valid != '0) chk_ev("resp_event", mk_ev(K_VAL, enc(warp_valid), warp_rdata));
            if (warp_err != '0)  chk_ev("err_event", mk_ev(K_ERR, enc(warp_err), 32'h0));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n     = 1'b0;
        warp_req  = '0;
        mem_ready = 1'b0;
        mem_valid = 1'b0;
        mem_rdata = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic check_quiet(input string name);
        check({name, "_pulses"}, 64'({warp_ack, warp_valid, warp_err, mem_req, busy}), 64'h0);
        check({name, "_owner"}, 64'(owner), 64'h0);
        check({name, "_addr"}, 64'(mem_addr), 64'h0);
        check({name, "_rdata"}, 64'(warp_rdata), 64'h0);
    endtask

    // One transaction from ARB_IDLE. lat: 0 = ready/valid together, 1..TO =
    // response on that cycle after acceptance, <0 = never (timeout).
    task automatic txn(input logic [3:0] req, input int w, input bit hold,
                       input int stall, input int lat, input logic [31:0] data);
        logic [3:0] bw;
        int         n;
        bit         resp;
        bw   = 4'b0001 << w;
        resp = (lat >= 0) && (lat <= TO);
        exp_q.push_back(mk_ev(K_ACK, 4'(w), 32'h0));
        exp_q.push_back(mk_ev(K_MEM, 4'h0, addr_of(w)));
        if (resp) exp_q.push_back(mk_ev(K_VAL, 4'(w), data));
        else      exp_q.push_back(mk_ev(K_ERR, 4'(w), 32'h0));

        warp_req = req;
        @(negedge clk);
        check("ack_latency", 64'(warp_ack), 64'(bw));
        tick();
        if (!hold) warp_req = req & ~bw;
        mem_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            // Address changes after the grant must not reach memory.
            warp_addr[w*AW +: AW] = ~addr_of(w);
            @(negedge clk);
            check("stall_req_addr", 64'({mem_req, mem_addr, warp_err}), 64'({1'b1, addr_of(w), 4'h0}));
            tick();
        end
        warp_addr[w*AW +: AW] = addr_of(w);
        mem_ready = 1'b1;
        mem_valid = (lat == 0);
        mem_rdata = data;
        @(negedge clk);
        check("issue_req_addr", 64'({mem_req, mem_addr}), 64'({1'b1, addr_of(w)}));
        if (lat == 0) check("combined_resp", 64'({warp_valid, warp_rdata}), 64'({bw, data}));
        tick();
        mem_ready = 1'b0;
        mem_valid = 1'b0;
        if (lat != 0) begin
            n = resp ? lat : TO;
            for (int k = 1; k < n; k++) begin
                @(negedge clk);
                check("wait_quiet", 64'({warp_valid, warp_err, mem_req}), 64'h0);
                tick();
            end
            mem_valid = resp;
            mem_rdata = data;
            @(negedge clk);
            if (resp) check("resp_timing", 64'({warp_valid, warp_err, warp_rdata}), 64'({bw, 4'h0, data}));
            else      check("err_timing", 64'({warp_valid, warp_err}), 64'({4'h0, bw}));
            tick();
            mem_valid = 1'b0;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        warp_req  = '0;
        mem_ready = 1'b0;
        mem_valid = 1'b0;
        mem_rdata = '0;
`ifdef WARP_FETCH_ARB_PRIO_EN
        warp_prio = '0;
`endif
        for (int w = 0; w < NW; w++) warp_addr[w*AW +: AW] = addr_of(w);
        #3;
        check_quiet("reset");
        do_reset();

        // Single request from warp 2.
        txn(4'b0100, 2, 1'b0, 0, 2, 32'hDEAD_BEEF);
        check("after_single_owner_busy", 64'({owner, busy}), 64'({2'd2, 1'b0}));

        // rr_ptr is now 3: warp 3 beats warp 0; combined ready/valid path.
        txn(4'b1001, 3, 1'b0, 0, 0, 32'hCAFE_0003);
        txn(4'b0001, 0, 1'b0, 0, 1, 32'h1111_0000);

        // All warps requesting continuously from a fresh reset.
        do_reset();
        for (int g = 0; g < 5; g++) txn(4'b1111, g % 4, 1'b1, 0, 1, 32'hA000_0000 + 32'(g));
        warp_req = '0;

        // Back-pressure for 10 cycles in ARB_ISSUE (rr_ptr=1).
        txn(4'b0010, 1, 1'b0, 10, 3, 32'h5555_AAAA);

        // Timeout on warp 2, then warp 1 still waiting is granted.
        txn(4'b0110, 2, 1'b0, 0, -1, 32'h0);
        txn(4'b0010, 1, 1'b0, 0, 1, 32'h2222_0001);

        // Response lands exactly on the timeout cycle.
        txn(4'b0100, 2, 1'b0, 0, TO, 32'h0BAD_F00D);

        // Reset while waiting for memory.
        do_reset();
        exp_q.push_back(mk_ev(K_ACK, 4'd2, 32'h0));
        exp_q.push_back(mk_ev(K_MEM, 4'h0, addr_of(2)));
        warp_req = 4'b0100;
        @(negedge clk);
        check("rst_case_ack", 64'(warp_ack), 64'(4'b0100));
        tick();
        warp_req  = 4'b0000;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        check("rst_case_in_wait", 64'(busy), 64'(1'b1));
        rst_n     = 1'b0;
        mem_valid = 1'b1;
        mem_rdata = 32'h7777_7777;
        warp_req  = 4'b1010;
        #1;
        check_quiet("mid_reset");
        tick();
        warp_req = 4'b0000;
        rst_n    = 1'b1;
        @(negedge clk);
        check("late_valid_ignored", 64'({warp_valid, warp_err, busy, warp_rdata}), 64'h0);
        tick();
        mem_valid = 1'b0;
        txn(4'b0001, 0, 1'b0, 0, 1, 32'h3333_0000);

`ifdef WARP_FETCH_ARB_PRIO_EN
        do_reset();
        warp_prio = 4'b1000;
        txn(4'b1011, 3, 1'b0, 0, 1, 32'h4444_0003);
        txn(4'b0011, 0, 1'b0, 0, 1, 32'h4444_0000);
        txn(4'b0010, 1, 1'b0, 0, 1, 32'h4444_0001);
        warp_prio = 4'b0000;
`endif

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("queue_drained", 64'(exp_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/warp_fetch_arbiter.md
Name: warp_fetch_arbiter

Overview:
- Shares the single instruction-memory port between NUM_WARPS warp controllers.
- Each controller fetches kernel instructions in its LOAD state by raising a request with an address.
- The arbiter grants one requester at a time in round-robin order and allows one outstanding transaction.
- It routes the memory response back to the owning warp and aborts hung transactions with a timeout.

Parameters:
- NUM_WARPS, 4, number of requesting warp controllers (2..16).
- ADDR_W, 32, fetch address width.
- DATA_W, 32, instruction width.
- TIMEOUT_CYCLES, 256, maximum cycles to wait for mem_valid after acceptance (>=2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- warp_req  in  NUM_WARPS  per-warp fetch request; level, held until warp_ack.
- warp_addr  in  NUM_WARPS*ADDR_W  packed per-warp fetch address; warp i at [i*ADDR_W +: ADDR_W].
- warp_ack  out  NUM_WARPS  one-hot pulse: request from warp i latched.
- warp_valid  out  NUM_WARPS  one-hot pulse: response for warp i on warp_rdata.
- warp_err  out  NUM_WARPS  one-hot pulse: warp i transaction timed out.
- warp_rdata  out  DATA_W  response data, broadcast; qualified by warp_valid.
- mem_req  out  1  request to memory.
- mem_addr  out  ADDR_W  request address.
- mem_ready  in  1  memory accepts; transfer when mem_req && mem_ready.
- mem_valid  in  1  response valid.
- mem_rdata  in  DATA_W  response data.
- owner  out  $clog2(NUM_WARPS)  index of the current or last granted warp.
- busy  out  1  high in any state other than ARB_IDLE.

Behaviour:
- Reset (async, rst_n low):
  - state=ARB_IDLE, rr_ptr=0, owner=0, addr_r=0, timer=0.
  - All outputs 0; warp_rdata=0.
  - Reset mid-transaction drops the transaction silently; no warp_err is raised.
- ARB_IDLE:
  - If any warp_req is set, pick the first set bit searching from rr_ptr upward, with wrap-around.
  - In the same cycle, drive warp_ack[pick]=1 combinationally and latch owner=pick, addr_r=warp_addr[pick].
  - Next state is ARB_ISSUE.
  - If no request is set, stay in ARB_IDLE.
- ARB_ISSUE:
  - mem_req=1, mem_addr=addr_r.
  - mem_ready=1 with mem_valid=0: go to ARB_WAIT with timer=0.
  - mem_ready=1 with mem_valid=1 in the same cycle: respond immediately (as in ARB_WAIT) and go to ARB_IDLE.
  - mem_ready=0: stay; the timer does not run in ARB_ISSUE (memory back-pressure is legal).
- ARB_WAIT:
  - mem_req=0; timer increments each cycle.
  - On mem_valid: warp_valid[owner]=1, warp_rdata=mem_rdata (combinational pass-through, zero added latency). Set rr_ptr=(owner+1) mod NUM_WARPS and go to ARB_IDLE.
  - If timer==TIMEOUT_CYCLES-1 with no mem_valid: warp_err[owner]=1 for one cycle, rr_ptr advances as above, go to ARB_IDLE.
  - If mem_valid and the timeout coincide, mem_valid wins and no error is raised.
- Latency:
  - warp_req to warp_ack: 0 cycles from ARB_IDLE.
  - warp_ack to mem_req: 1 cycle.
  - Minimum round trip: 3 cycles (IDLE, ISSUE accepted, WAIT response), or 2 cycles with a combined ready/valid in ARB_ISSUE.
- Handshake rules:
  - A requester deasserting warp_req before warp_ack is legal and is simply not granted.
  - After warp_ack, warp_req/addr changes are ignored until warp_valid or warp_err.
- Fairness and responses:
  - With all warps requesting, grants cycle 0,1,...,NUM_WARPS-1,0,...
  - mem_valid outside ARB_WAIT/ARB_ISSUE is ignored and never routed.
- Width rules:
  - rr_ptr/owner wrap modulo NUM_WARPS, including non-power-of-2 values.
  - The timer is $clog2(TIMEOUT_CYCLES)+1 bits.
- Encoding: unused state encodings return to ARB_IDLE with no output pulse.

Optional Feature:
- Macro: WARP_FETCH_ARB_PRIO_EN.
- When defined:
  - Adds input warp_prio [NUM_WARPS].
  - In ARB_IDLE, if any (warp_req & warp_prio) bit is set, arbitration uses only that masked set, with round-robin from rr_ptr inside it.
  - Otherwise arbitration covers all requests.
  - A single rr_ptr is shared by both classes.
- When undefined: no port, pure round-robin.

Decomposition:
- warp_pkg gains:
  - arb_state_e {ARB_IDLE, ARB_ISSUE, ARB_WAIT};
  - NUM_WARPS_DEFAULT=4;
  - ARB_TIMEOUT_DEFAULT=256.
- Sub-module warp_rr_pick, purely combinational:
  - inputs: req mask, ptr;
  - outputs: found, index (first set bit at or after ptr, with wrap).
  - Reused by the arbiter for both priority classes.

Test Plan:
- Single request: warp_req=4'b0100, addr 0x1000, mem_ready=1, mem_valid 2 cycles later with data 0xDEADBEEF → warp_ack[2] in cycle 0, mem_req/mem_addr=0x1000 in cycle 1, warp_valid[2] with 0xDEADBEEF, owner=2, rr_ptr=3.
- All four warps requesting continuously, 1-cycle memory response → grant order 0,1,2,3,0; each warp_ack exactly once per rotation.
- mem_ready held low 10 cycles in ARB_ISSUE → mem_req/mem_addr stable, no timeout; acceptance on cycle 11 proceeds normally.
- TIMEOUT_CYCLES=8, mem_valid never asserted → warp_err[owner] pulses 8 cycles after acceptance, back to ARB_IDLE, next requester granted.
- mem_valid on the exact timeout cycle → warp_valid pulse, no warp_err.
- rst_n asserted low in ARB_WAIT → all outputs 0 immediately; after release, the late mem_valid is ignored and warp_req=4'b0001 is granted afresh.
- With WARP_FETCH_ARB_PRIO_EN, warp_req=4'b1011, warp_prio=4'b1000, rr_ptr=0 → warp 3 granted first, then 0, then 1.
